// File: rtl/exp_request_scheduler.sv
// exp_request_scheduler: round-robin sharing of one fixed-latency exp(-x) pipeline among
// N_REQ requesters, with per-requester credits and an id tag pipe that routes results back.
module exp_request_scheduler #(
  parameter int          N_REQ   = 4,
  parameter int          LATENCY = 20,
  parameter int          MAX_OUT = 8,
  parameter logic [63:0] XMAX    = 64'h0000_002C_0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [64*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]    req_ready,
  output logic [63:0]         exp_x,
  input  logic [63:0]         exp_y,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [63:0]         rsp_y,
  output logic                busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  // one tag stage rides alongside the exp_x register, then LATENCY more line up with exp_y
  localparam int D = LATENCY + 1;
  logic [IW-1:0] ptr, gid;
  logic          gnt, gz;
  logic [63:0]   gx;
  logic [N_REQ-1:0] elig;
  logic [CW-1:0] cnt [N_REQ];
  logic [D-1:0]  tv, tz;
  logic [IW-1:0] tid [D];
  int            idx;
  always_comb begin
    elig = '0;
    gnt = 1'b0;
    gid = '0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) elig[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUT));
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = (idx >= N_REQ) ? idx - N_REQ : idx;
      if (elig[idx]) begin
        gnt = 1'b1;
        gid = IW'(idx);
      end
    end
  end
  assign req_ready = gnt ? (N_REQ'(1) << gid) : '0;
  assign gx        = req_x[64*gid +: 64];
  assign gz        = gx >= XMAX;
  assign busy      = (|tv) || (|rsp_valid);
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      exp_x     <= '0;
      tv        <= '0;
      tz        <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      for (int d = 0; d < D; d++) tid[d] <= '0;
    end else begin
      if (gnt) ptr <= (gid == IW'(N_REQ - 1)) ? '0 : gid + IW'(1);
      exp_x  <= (gnt && !gz) ? gx : '0;
      tv     <= {tv[D-2:0], gnt};
      tz     <= {tz[D-2:0], gnt && gz};
      tid[0] <= gid;
      for (int d = 1; d < D; d++) tid[d] <= tid[d-1];
      rsp_valid <= tv[D-1] ? (N_REQ'(1) << tid[D-1]) : '0;
      if (tv[D-1]) rsp_y <= tz[D-1] ? '0 : exp_y;
      // grant and release on the same requester cancel out
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= cnt[i] + CW'(gnt && gid == IW'(i)) - CW'(tv[D-1] && tid[D-1] == IW'(i));
    end
  end
endmodule

// File: tb/tb_exp_request_scheduler.sv
// tb_exp_request_scheduler: vector table, hand sequences and random traffic checked against a queue-based model.
module tb_exp_request_scheduler;
  localparam int N = 4, L = 20, M = 8;
  localparam logic [63:0] XMAX = 64'h0000_002C_0000_0000;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, seen_ready, exp_rv;
  logic [64*N-1:0] req_x = '0;
  logic [63:0] exp_x, exp_y, rsp_y, last_y = '0, exp_xm;
  logic busy;
  logic [63:0] upipe [L];
  int total = 0, bad = 0;
  typedef struct { int due; int id; logic [63:0] y; } ent_t;
  ent_t q[$];
  int mcnt [N];
  int mptr = 0, edge_n = 0;
  typedef struct { logic [N-1:0] v; logic [63:0] x; logic [N-1:0] rdy; logic [63:0] ex; } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  exp_request_scheduler #(.N_REQ(N), .LATENCY(L), .MAX_OUT(M), .XMAX(XMAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .exp_x(exp_x), .exp_y(exp_y), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .busy(busy));

  // stand-in exponent unit: an arbitrary bijective scramble behind L register stages
  function automatic logic [63:0] fexp(input logic [63:0] x);
    return {~x[31:0], x[63:32]} ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) upipe[i] <= '0;
    end else begin
      upipe[0] <= fexp(exp_x);
      for (int i = 1; i < L; i++) upipe[i] <= upipe[i-1];
    end
  end
  assign exp_y = upipe[L-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, want);
    end
  endtask

  task automatic step();
    int g = -1;
    int c;
    logic [63:0] x;
    #1;
    if (rst) begin
      for (int k = N - 1; k >= 0; k--) begin
        c = (mptr + k) % N;
        if (req_valid[c] && mcnt[c] < M) g = c;
      end
      chk("ready", 64'(req_ready), g >= 0 ? (64'(1) << g) : 64'(0));
    end
    seen_ready = req_ready;
    @(posedge clk);
    edge_n++;
    exp_rv = '0;
    exp_xm = '0;
    if (!rst) begin
      q.delete();
      foreach (mcnt[i]) mcnt[i] = 0;
      mptr = 0;
      last_y = '0;
    end else begin
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_rv = N'(1) << q[0].id;
        last_y = q[0].y;
        mcnt[q[0].id]--;
        void'(q.pop_front());
      end
      if (g >= 0) begin
        x = req_x[64*g +: 64];
        exp_xm = x >= XMAX ? 64'(0) : x;
        q.push_back('{due: edge_n + L + 1, id: g, y: (x >= XMAX ? 64'(0) : fexp(x))});
        mcnt[g]++;
        mptr = (g + 1) % N;
      end
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_y", rsp_y, last_y);
    chk("busy", 64'(busy), 64'(q.size() > 0 || exp_rv != 0));
    chk("exp_x", exp_x, exp_xm);
  endtask

  initial begin
    int n, cnt_a, cnt_b;
    logic drop;
    foreach (mcnt[i]) mcnt[i] = 0;
    tbl[0] = '{4'b0000, 64'h5,                   4'b0000, 64'h0};
    tbl[1] = '{4'b1111, 64'hD3A1_DB40,           4'b0001, 64'hD3A1_DB40};
    tbl[2] = '{4'b1111, XMAX,                    4'b0010, 64'h0};
    tbl[3] = '{4'b0101, XMAX - 1,                4'b0100, XMAX - 1};
    tbl[4] = '{4'b0101, 64'h0,                   4'b0001, 64'h0};
    tbl[5] = '{4'b0101, 64'h1_0000_0000,         4'b0100, 64'h1_0000_0000};
    tbl[6] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 64'h0};
    tbl[7] = '{4'b0110, 64'h7_1234_5678,         4'b0010, 64'h7_1234_5678};
    tbl[8] = '{4'b1001, 64'h2B_0000_0001,        4'b1000, 64'h2B_0000_0001};
    step();
    step();
    rst = 1;
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].v;
      req_x = {N{tbl[i].x}};
      step();
      chk("tbl_ready", 64'(seen_ready), 64'(tbl[i].rdy));
      chk("tbl_exp_x", exp_x, tbl[i].ex);
    end
    req_valid = '0;
    repeat (25) step();
    // single request: latency and busy window
    req_valid = 4'b0001;
    req_x[63:0] = 64'h0000_0000_D3A1_DB40;
    step();
    req_valid = '0;
    n = 0;
    drop = 0;
    while (n < 40 && rsp_valid == '0) begin
      if (!busy) drop = 1;
      step();
      n++;
    end
    chk("latency", 64'(n), 64'(L + 1));
    chk("single_onehot", 64'(rsp_valid), 64'b0001);
    chk("single_y", rsp_y, fexp(64'h0000_0000_D3A1_DB40));
    chk("busy_mid", 64'(drop), 64'(0));
    step();
    chk("busy_after", 64'(busy), 64'(0));
    chk("single_strobe", 64'(rsp_valid), 64'(0));
    // reset mid-flight
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < N; r++) req_x[64*r +: 64] = 64'(i * 977 + r * 31);
      step();
    end
    req_valid = '0;
    repeat (2) step();
    rst = 0;
    step();
    rst = 1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_y", rsp_y, 64'(0));
    n = 0;
    repeat (25) begin
      step();
      if (rsp_valid != '0) n++;
    end
    chk("rst_no_stale", 64'(n), 64'(0));
    // credit limit on requester 1
    req_valid = 4'b0010;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 42; i++) begin
      req_x[127:64] = 64'(i) * 64'h1_2345_6789;
      step();
      if (seen_ready[1]) begin
        if (i < L + 1) cnt_a++;
        cnt_b++;
      end
    end
    chk("credit_first", 64'(cnt_a), 64'(M));
    chk("credit_total", 64'(cnt_b), 64'(2 * M));
    req_valid = '0;
    repeat (25) step();
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      req_valid = ((i / 100) % 2 == 0) ? N'($urandom) : (N'(1) << ((i / 200) % N));
      for (int r = 0; r < N; r++) begin
        case ($urandom_range(0, 5))
          0: req_x[64*r +: 64] = XMAX;
          1: req_x[64*r +: 64] = XMAX - 1;
          2: req_x[64*r +: 64] = 64'h0;
          3: req_x[64*r +: 64] = {$urandom, $urandom};
          default: req_x[64*r +: 64] = {32'($urandom_range(0, 50)), $urandom};
        endcase
      end
      step();
    end
    rst = 1;
    req_valid = '0;
    repeat (30) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
